// File: rtl/rv32i_pkg.sv
// Shared fetch-stage types and constants for the RV32I front end.
package rv32i_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr} entries with synchronous flush.
// The head reads as all-zero while the queue is empty.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = 1;
    localparam logic [PW:0]     CNT_ONE  = 1;
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic w_wr_en;
    logic w_rd_en;
    logic w_empty;

    assign w_empty = (r_count == '0);
    assign w_wr_en = push & ~reset & ~flush;
    assign w_rd_en = pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_FULL);
    assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and feeds
// captured {pc, instr} pairs to decode through a small prefetch queue.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_fetch_count;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_q_full;
    logic [$clog2(DEPTH):0] w_q_count;
    fetch_entry_t           w_push_data;
    fetch_entry_t           w_head;

    assign if_valid = (w_q_count != '0);

    // A redirect voids the current head, so it neither pops nor pushes.
    assign w_pop  = if_valid & id_ready & ~redirect_valid;
    assign w_push = fetch_en & ~redirect_valid & (~w_q_full | w_pop);

    assign w_push_data.pc    = r_fetch_pc;
    assign w_push_data.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc    <= r_fetch_pc + PC_STEP;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_q_full),
        .count     (w_q_count)
    );

    assign imem_addr   = r_fetch_pc;
    assign if_pc       = w_head.pc;
    assign if_instr    = w_head.instr;
    assign fetch_count = r_fetch_count;

endmodule
